// File: rtl/spi_flash_range_sequencer_if.sv
// rtl/spi_flash_range_sequencer_if.sv - burst command handshake between sequencer and QSPI controller
interface spi_flash_range_sequencer_if #(
    parameter int DIE_BYTES_LOG2 = 25,
    parameter int NUM_DIES       = 2,
    parameter int MAX_BURST      = 256
);
    localparam int DIE_W = (NUM_DIES > 1) ? $clog2(NUM_DIES) : 1;
    localparam int LEN_W = $clog2(MAX_BURST + 1);

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [DIE_W-1:0]          cmd_die;
    logic [DIE_BYTES_LOG2-1:0] cmd_addr;
    logic [LEN_W-1:0]          cmd_len;
    logic [1:0]                cmd_mode;
    logic                      burst_done;

    modport master (
        output cmd_valid, cmd_die, cmd_addr, cmd_len, cmd_mode,
        input  cmd_ready, burst_done
    );

    modport slave (
        input  cmd_valid, cmd_die, cmd_addr, cmd_len, cmd_mode,
        output cmd_ready, burst_done
    );
endinterface

// File: rtl/spi_flash_range_sequencer.sv
// rtl/spi_flash_range_sequencer.sv - splits an inclusive byte range into die-bounded, FIFO-bounded read bursts
module spi_flash_range_sequencer #(
    parameter int ADDR_W         = 32,
    parameter int DIE_BYTES_LOG2 = 25,
    parameter int NUM_DIES       = 2,
    parameter int MAX_BURST      = 256
) (
    input  logic                                       system_clk,
    input  logic                                       system_reset_n,
    input  logic                                       start_flag,
    input  logic [ADDR_W-1:0]                          start_addr,
    input  logic [ADDR_W-1:0]                          end_addr,
    input  logic [1:0]                                 mode,
    input  logic                                       abort,
    input  logic [$clog2(MAX_BURST+1)-1:0]             fifo_free,
    spi_flash_range_sequencer_if.master                cmd_if,
    output logic                                       busy,
    output logic                                       read_finish,
    output logic [1:0]                                 finish_status
);
    localparam int DIE_W = (NUM_DIES > 1) ? $clog2(NUM_DIES) : 1;
    localparam int LEN_W = $clog2(MAX_BURST + 1);

    // All range arithmetic is one bit wider than the address so no term wraps before the min.
    localparam logic [ADDR_W:0] ONE        = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] DIE_MASK   = (ADDR_W+1)'((64'd1 << DIE_BYTES_LOG2) - 64'd1);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(64'(NUM_DIES) << DIE_BYTES_LOG2);
    localparam logic [ADDR_W:0] BURST_MAX  = (ADDR_W+1)'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CALC,
        S_ISSUE,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_curr_addr;
    logic [ADDR_W-1:0] r_end_q;
    logic [1:0]        r_mode_q;
    logic [1:0]        r_status;
    logic              r_abort_q;
    logic [LEN_W-1:0]  r_len_q;

    logic [ADDR_W:0]   w_curr_ext;
    logic [ADDR_W:0]   w_end_ext;
    logic [ADDR_W:0]   w_range_left;
    logic [ADDR_W:0]   w_die_left;
    logic [ADDR_W:0]   w_fifo_ext;
    logic [ADDR_W:0]   w_min;
    logic [ADDR_W:0]   w_last;
    logic              w_param_err;
    logic              w_fifo_ok;

    always_comb begin
        w_curr_ext   = {1'b0, r_curr_addr};
        w_end_ext    = {1'b0, r_end_q};
        w_range_left = w_end_ext - w_curr_ext + ONE;
        w_die_left   = (w_curr_ext | DIE_MASK) - w_curr_ext + ONE;
        w_fifo_ext   = (ADDR_W+1)'(fifo_free);
        w_min        = BURST_MAX;
        if (w_range_left < w_min) w_min = w_range_left;
        if (w_die_left < w_min)   w_min = w_die_left;
        if (w_fifo_ext < w_min)   w_min = w_fifo_ext;
        w_last       = w_curr_ext + (ADDR_W+1)'(r_len_q) - ONE;
        w_param_err  = (w_end_ext < w_curr_ext) || (r_mode_q == 2'd3) || (w_end_ext >= ADDR_LIMIT);
        w_fifo_ok    = (fifo_free != '0);
    end

    always_ff @(posedge system_clk) begin
        if (!system_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:      if (start_flag) w_state_nxt = S_CHECK;
            S_CHECK:     w_state_nxt = w_param_err ? S_FINISH : S_CALC;
            S_CALC: begin
                if (r_abort_q)      w_state_nxt = S_FINISH;
                else if (w_fifo_ok) w_state_nxt = S_ISSUE;
            end
            S_ISSUE:     if (cmd_if.cmd_ready) w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (cmd_if.burst_done) w_state_nxt = (w_last == w_end_ext) ? S_FINISH : S_CALC;
            end
            S_FINISH:    w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (!system_reset_n) begin
            r_curr_addr <= '0;
            r_end_q     <= '0;
            r_mode_q    <= '0;
            r_status    <= '0;
            r_abort_q   <= 1'b0;
            r_len_q     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_abort_q <= 1'b0;
                    if (start_flag) begin
                        r_curr_addr <= start_addr;
                        r_end_q     <= end_addr;
                        r_mode_q    <= mode;
                        r_status    <= 2'd0;
                    end
                end
                S_CHECK:     if (w_param_err) r_status <= 2'd2;
                S_CALC: begin
                    if (r_abort_q)      r_status <= 2'd1;
                    else if (w_fifo_ok) r_len_q  <= LEN_W'(w_min);
                end
                S_WAIT_DONE: if (cmd_if.burst_done) r_curr_addr <= r_curr_addr + ADDR_W'(r_len_q);
                default: ;
            endcase
            // Abort is remembered from any active state and only acted on between bursts.
            if (r_state != S_IDLE && abort) r_abort_q <= 1'b1;
        end
    end

    assign cmd_if.cmd_valid = (r_state == S_ISSUE);
    assign cmd_if.cmd_die   = r_curr_addr[DIE_BYTES_LOG2 +: DIE_W];
    assign cmd_if.cmd_addr  = r_curr_addr[DIE_BYTES_LOG2-1:0];
    assign cmd_if.cmd_len   = r_len_q;
    assign cmd_if.cmd_mode  = r_mode_q;
    assign busy             = (r_state != S_IDLE);
    assign read_finish      = (r_state == S_FINISH);
    assign finish_status    = (r_state == S_FINISH) ? r_status : 2'd0;
endmodule

// File: tb/tb_spi_flash_range_sequencer.sv
// tb/tb_spi_flash_range_sequencer.sv - randomized bench with a range-level reference model
module tb_spi_flash_range_sequencer;
    localparam int     ADDR_W    = 32;
    localparam int     DBL       = 25;
    localparam int     NUM_DIES  = 2;
    localparam int     MAX_BURST = 256;
    localparam longint DIE_SZ    = 64'd1 << DBL;

    typedef struct {
        longint die;
        longint addr;
        longint len;
        int     mode;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_flag = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] start_addr = '0;
    logic [31:0] end_addr = '0;
    logic [1:0]  mode = '0;
    logic [8:0]  fifo_free = '0;
    logic        busy;
    logic        read_finish;
    logic [1:0]  finish_status;

    spi_flash_range_sequencer_if #(.DIE_BYTES_LOG2(DBL), .NUM_DIES(NUM_DIES), .MAX_BURST(MAX_BURST)) cif();

    spi_flash_range_sequencer #(
        .ADDR_W(ADDR_W), .DIE_BYTES_LOG2(DBL), .NUM_DIES(NUM_DIES), .MAX_BURST(MAX_BURST)
    ) dut (
        .system_clk(clk), .system_reset_n(rst_n), .start_flag(start_flag),
        .start_addr(start_addr), .end_addr(end_addr), .mode(mode), .abort(abort),
        .fifo_free(fifo_free), .cmd_if(cif.master), .busy(busy),
        .read_finish(read_finish), .finish_status(finish_status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Controller emulation knobs
    bit fifo_rand = 0;
    bit abort_rand = 0;
    bit spurious = 0;
    bit slow_done = 0;
    int ready_block = 0;

    // Observations of the DUT for literal checks
    cmd_t       log_q[$];
    int         fin_count = 0;
    logic [1:0] last_status = '0;
    int         fin_cyc = 0;
    int         st_cyc = 0;

    // Reference model state
    bit         m_active = 0, m_issuing = 0, m_inflight = 0, m_waiting = 0, m_abort = 0, m_zero = 0;
    int         m_finish_at = -1, m_calc_from = 0;
    longint     m_cur = 0, m_end = 0;
    int         m_mode = 0;
    logic [1:0] m_status = '0;
    cmd_t       e_cmd;

    function automatic longint min2(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    initial begin : compare
        forever begin
            @(negedge clk);
            if (m_zero) begin
                chk("reset_outputs", {cif.cmd_valid, busy, read_finish, finish_status, cif.cmd_die,
                                      cif.cmd_addr, cif.cmd_len, cif.cmd_mode}, 64'd0);
            end else begin
                chk("busy", busy, m_active);
                chk("read_finish", read_finish, m_active && cyc == m_finish_at);
                if (m_active && cyc == m_finish_at) chk("finish_status", finish_status, m_status);
                chk("cmd_valid", cif.cmd_valid, m_issuing);
                if (m_issuing && cif.cmd_valid) begin
                    chk("cmd_die", cif.cmd_die, e_cmd.die);
                    chk("cmd_addr", cif.cmd_addr, e_cmd.addr);
                    chk("cmd_len", cif.cmd_len, e_cmd.len);
                    chk("cmd_mode", cif.cmd_mode, e_cmd.mode);
                end
            end
            if (read_finish) begin
                fin_count++;
                last_status = finish_status;
                fin_cyc = cyc;
            end
            if (rst_n && !busy && start_flag) st_cyc = cyc;
            if (cif.cmd_valid && cif.cmd_ready)
                log_q.push_back('{longint'(cif.cmd_die), longint'(cif.cmd_addr), longint'(cif.cmd_len), int'(cif.cmd_mode)});

            if (!rst_n) begin
                m_active = 0; m_issuing = 0; m_inflight = 0; m_waiting = 0; m_abort = 0;
                m_finish_at = -1; m_zero = 1;
            end else begin
                m_zero = 0;
                if (!m_active) begin
                    if (start_flag) begin
                        m_cur = longint'(start_addr); m_end = longint'(end_addr); m_mode = int'(mode);
                        m_active = 1; m_abort = 0;
                        if (m_end < m_cur || m_mode == 3 || m_end >= NUM_DIES * DIE_SZ) begin
                            m_finish_at = cyc + 2; m_status = 2'd2;
                        end else begin
                            m_waiting = 1; m_calc_from = cyc + 2; m_finish_at = -1;
                        end
                    end
                end else begin
                    if (m_issuing && cif.cmd_ready) begin
                        m_issuing = 0; m_inflight = 1;
                    end else if (m_inflight && cif.burst_done) begin
                        m_cur += e_cmd.len; m_inflight = 0;
                        if (m_cur > m_end) begin
                            m_finish_at = cyc + 1; m_status = 2'd0;
                        end else begin
                            m_waiting = 1; m_calc_from = cyc + 1;
                        end
                    end else if (m_waiting && cyc >= m_calc_from) begin
                        if (m_abort) begin
                            m_waiting = 0; m_finish_at = cyc + 1; m_status = 2'd1;
                        end else if (fifo_free != 0) begin
                            e_cmd.die  = m_cur / DIE_SZ;
                            e_cmd.addr = m_cur % DIE_SZ;
                            e_cmd.len  = min2(min2(MAX_BURST, m_end - m_cur + 1),
                                              min2(DIE_SZ - (m_cur % DIE_SZ), longint'(fifo_free)));
                            e_cmd.mode = m_mode;
                            m_issuing = 1; m_waiting = 0;
                        end
                    end
                    if (abort) m_abort = 1;
                    if (cyc == m_finish_at) begin
                        m_active = 0; m_abort = 0;
                    end
                end
            end
        end
    end

    initial begin : controller
        bit acc;
        bit v_seen;
        bit hs;
        int dcnt;
        acc = 0; v_seen = 0; dcnt = 0;
        cif.cmd_ready = 1'b0;
        cif.burst_done = 1'b0;
        forever begin
            @(posedge clk);
            hs = v_seen && cif.cmd_ready;
            if (!rst_n) begin
                acc = 0; dcnt = 0;
            end else if (hs) begin
                acc = 1; dcnt = slow_done ? 30 : $urandom_range(1, 4);
            end
            #1;
            cif.burst_done = 1'b0;
            cif.cmd_ready = 1'b0;
            if (acc) begin
                dcnt--;
                if (dcnt == 0) begin
                    cif.burst_done = 1'b1; acc = 0;
                end
            end else if (spurious && $urandom_range(0, 9) == 0) begin
                cif.burst_done = 1'b1;
            end
            if (cif.cmd_valid && !acc) begin
                if (ready_block > 0) ready_block--;
                else cif.cmd_ready = ($urandom_range(0, 2) == 0);
            end else if (spurious) begin
                cif.cmd_ready = ($urandom_range(0, 4) == 0);
            end
            v_seen = cif.cmd_valid;
            if (fifo_rand) fifo_free = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(1, 256));
            if (abort_rand) abort = ($urandom_range(0, 29) == 0);
        end
    end

    initial begin : watchdog
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    int fin_base = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn(input longint s, input longint e, input logic [1:0] md);
        int w;
        w = 0;
        while (busy && w < 3000) begin tick(); w++; end
        if (busy) chk("idle_timeout", busy, 0);
        log_q.delete();
        fin_base = fin_count;
        start_addr = s[31:0];
        end_addr = e[31:0];
        mode = md;
        start_flag = 1'b1;
        tick();
        start_flag = 1'b0;
    endtask

    task automatic wait_fin();
        int w;
        w = 0;
        while (fin_count == fin_base && w < 20000) begin tick(); w++; end
        if (fin_count == fin_base) chk("finish_timeout", 0, 1);
        tick();
    endtask

    task automatic run_txn(input longint s, input longint e, input logic [1:0] md);
        start_txn(s, e, md);
        wait_fin();
    endtask

    initial begin : main
        longint s, e, sum;
        int     w, r;
        logic [1:0] md;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        spurious = 1;

        // Single aligned 256-byte burst
        fifo_free = 9'd256;
        run_txn(64'h100, 64'h1FF, 2'd2);
        chk("t1_ncmd", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            chk("t1_die", log_q[0].die, 0);
            chk("t1_addr", log_q[0].addr, 64'h100);
            chk("t1_len", log_q[0].len, 256);
            chk("t1_mode", log_q[0].mode, 2);
        end
        chk("t1_status", last_status, 0);

        // Range straddling the die boundary
        run_txn(64'h01FF_FFF0, 64'h0200_000F, 2'd0);
        chk("t2_ncmd", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            chk("t2_c0", {log_q[0].die[7:0], log_q[0].addr[31:0], log_q[0].len[15:0]}, {8'd0, 32'h01FF_FFF0, 16'd16});
            chk("t2_c1", {log_q[1].die[7:0], log_q[1].addr[31:0], log_q[1].len[15:0]}, {8'd1, 32'h0, 16'd16});
        end
        chk("t2_status", last_status, 0);

        // Parameter errors
        run_txn(64'h20, 64'h10, 2'd1);
        chk("t3a_ncmd", log_q.size(), 0);
        chk("t3a_status", last_status, 2);
        chk("t3a_latency", fin_cyc - st_cyc, 2);
        run_txn(64'h0, 64'h10, 2'd3);
        chk("t3b_status", last_status, 2);
        chk("t3b_latency", fin_cyc - st_cyc, 2);
        start_txn(64'h40, 64'h4_000_000, 2'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        wait_fin();
        chk("t3c_status", last_status, 2);

        // FIFO-limited bursts, with an initial starvation window
        fifo_free = 9'd0;
        start_txn(64'h0, 64'h3FF, 2'd1);
        repeat (20) tick();
        chk("t4_stall_ncmd", log_q.size(), 0);
        fifo_free = 9'd100;
        wait_fin();
        sum = 0;
        foreach (log_q[i]) sum += log_q[i].len;
        chk("t4_sum", sum, 1024);
        chk("t4_ncmd", log_q.size(), 11);
        if (log_q.size() == 11) begin
            chk("t4_first", log_q[0].len, 100);
            chk("t4_last", log_q[10].len, 24);
        end
        chk("t4_status", last_status, 0);

        // Abort while the command is back-pressured
        fifo_free = 9'd256;
        ready_block = 10;
        start_txn(64'h0, 64'h3FF, 2'd1);
        w = 0;
        while (!cif.cmd_valid && w < 50) begin tick(); w++; end
        chk("t5_valid_seen", cif.cmd_valid, 1);
        repeat (3) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        wait_fin();
        chk("t5_ncmd", log_q.size(), 1);
        chk("t5_status", last_status, 1);

        // Reset while a burst is in flight
        slow_done = 1;
        start_txn(64'h0, 64'h3FF, 2'd2);
        w = 0;
        while (log_q.size() == 0 && w < 100) begin tick(); w++; end
        chk("t6_accepted", log_q.size(), 1);
        repeat (2) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        slow_done = 0;
        chk("t6_busy_after_reset", busy, 0);
        chk("t6_valid_after_reset", cif.cmd_valid, 0);
        repeat (5) tick();
        chk("t6_no_reissue", cif.cmd_valid, 0);
        run_txn(64'h40, 64'h40, 2'd0);
        chk("t6_ncmd", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            chk("t6_addr", log_q[0].addr, 64'h40);
            chk("t6_len", log_q[0].len, 1);
        end
        chk("t6_status", last_status, 0);

        // Randomized ranges, FIFO levels, modes and aborts
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            s = longint'($urandom_range(0, 32'(2 * DIE_SZ - 1)));
            if (r < 3) s = DIE_SZ - longint'($urandom_range(1, 600));
            e = s + longint'($urandom_range(0, 1500));
            if (r == 9 && s >= 5) e = s - 5;
            if (r == 8) e = 2 * DIE_SZ + longint'($urandom_range(0, 10));
            md = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            fifo_rand = (k % 3 != 0);
            if (!fifo_rand) fifo_free = 9'($urandom_range(32, 256));
            abort_rand = (k % 4 == 1);
            run_txn(s, e, md);
            abort_rand = 0;
            abort = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
